// File: rtl/bsg_chip_link_reset_seq_pkg.sv
// Chip-level shared types for the link reset sequencer.
// Holds the sequencer state encoding, the default link count and the
// payload layout that the chip top uses to drive the sequencer from a tag client.
package bsg_chip_pkg;

  localparam int io_link_num_gp  = 2;
  localparam int mem_link_num_gp = 16;

  localparam int link_reset_seq_num_links_gp  = io_link_num_gp + mem_link_num_gp;
  localparam int link_reset_seq_wait_width_gp = 8;

  typedef enum logic [2:0] {
    e_lrs_idle,
    e_lrs_assert,
    e_lrs_io_rel,
    e_lrs_core_rel,
    e_lrs_done
  } bsg_link_reset_seq_state_e;

  typedef struct packed {
    logic                                      start;
    logic [link_reset_seq_wait_width_gp-1:0]   wait_cycles;
    logic [link_reset_seq_num_links_gp-1:0]    link_en;
  } bsg_link_reset_seq_tag_payload_s;

  // Index width that stays at least one bit wide for a single-link build.
  function automatic int bsg_safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_chip_link_reset_seq_if.sv
// Control/status bundle between a reset-sequencer controller and the sequencer.
// The controller side (master) requests sequencing and watches the per-link resets.
interface bsg_chip_link_reset_seq_if
  import bsg_chip_pkg::*;
#(
  parameter int num_links_p  = link_reset_seq_num_links_gp,
  parameter int wait_width_p = link_reset_seq_wait_width_gp
);

  localparam int lg_links_lp = bsg_safe_clog2(num_links_p);

  logic                    start_i;
  logic [num_links_p-1:0]  link_en_i;
  logic [wait_width_p-1:0] wait_cycles_i;
  logic [num_links_p-1:0]  io_reset_o;
  logic [num_links_p-1:0]  core_reset_o;
  logic [lg_links_lp-1:0]  cur_link_o;
  logic                    busy_o;
  logic                    done_o;

  modport master (
    output start_i, link_en_i, wait_cycles_i,
    input  io_reset_o, core_reset_o, cur_link_o, busy_o, done_o
  );

  modport slave (
    input  start_i, link_en_i, wait_cycles_i,
    output io_reset_o, core_reset_o, cur_link_o, busy_o, done_o
  );

endinterface

// File: rtl/bsg_chip_link_reset_seq_next.sv
// Finds the lowest set bit of mask_i strictly above from_i (or at/above from_i
// when inclusive_i is set). Pure combinational, so skipping disabled links
// costs no cycles in the sequencer.
module bsg_chip_link_reset_seq_next
  import bsg_chip_pkg::*;
#(
  parameter int num_links_p = link_reset_seq_num_links_gp,
  localparam int lg_links_lp = bsg_safe_clog2(num_links_p)
) (
  input  logic [num_links_p-1:0] mask_i,
  input  logic [lg_links_lp-1:0] from_i,
  input  logic                   inclusive_i,
  output logic [lg_links_lp-1:0] idx_o,
  output logic                   found_o
);

  logic [num_links_p-1:0] masked;

  // Keep only candidates above the starting point, then priority-encode lowest-first.
  always_comb begin
    masked = '0;
    idx_o  = '0;
    for (int i = 0; i < num_links_p; i++) begin
      masked[i] = mask_i[i] &&
                  ((i > int'(from_i)) || (inclusive_i && (i == int'(from_i))));
    end
    for (int i = num_links_p - 1; i >= 0; i--) begin
      if (masked[i]) idx_o = lg_links_lp'(i);
    end
    found_o = |masked;
  end

endmodule

// File: rtl/bsg_chip_link_reset_seq.sv
// Sequences io then core reset release across the links, one link at a time,
// with a programmable hold on every phase. All outputs are registered.
module bsg_chip_link_reset_seq
  import bsg_chip_pkg::*;
#(
  parameter int num_links_p  = link_reset_seq_num_links_gp,
  parameter int wait_width_p = link_reset_seq_wait_width_gp
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  bsg_chip_link_reset_seq_if.slave  ctl_if
);

  localparam int lg_links_lp = bsg_safe_clog2(num_links_p);

  bsg_link_reset_seq_state_e state_r, state_n;
  logic [wait_width_p-1:0]   cnt_r, cnt_n;
  logic [wait_width_p-1:0]   w_r, w_n;
  logic [num_links_p-1:0]    mask_r, mask_n;
  logic [lg_links_lp-1:0]    cur_r, cur_n;
  logic [num_links_p-1:0]    io_reset_r, io_reset_n;
  logic [num_links_p-1:0]    core_reset_r, core_reset_n;
  logic                      busy_r, busy_n;
  logic                      done_r, done_n;

  logic [lg_links_lp-1:0]    next_idx;
  logic                      next_found;

  // From ASSERT the first enabled link is searched from bit 0 inclusive;
  // afterwards the search starts strictly above the current link.
  bsg_chip_link_reset_seq_next #(
    .num_links_p (num_links_p)
  ) next_finder (
    .mask_i      (mask_r),
    .from_i      ((state_r == e_lrs_assert) ? '0 : cur_r),
    .inclusive_i (state_r == e_lrs_assert),
    .idx_o       (next_idx),
    .found_o     (next_found)
  );

  // State and all outputs are flops; reset re-asserts every link reset at once.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= e_lrs_idle;
      cnt_r        <= '0;
      w_r          <= '0;
      mask_r       <= '0;
      cur_r        <= '0;
      io_reset_r   <= '1;
      core_reset_r <= '1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      w_r          <= w_n;
      mask_r       <= mask_n;
      cur_r        <= cur_n;
      io_reset_r   <= io_reset_n;
      core_reset_r <= core_reset_n;
      busy_r       <= busy_n;
      done_r       <= done_n;
    end
  end

  // Next-state logic; the counter only decrements while non-zero so it never wraps.
  always_comb begin
    state_n      = state_r;
    cnt_n        = cnt_r;
    w_n          = w_r;
    mask_n       = mask_r;
    cur_n        = cur_r;
    io_reset_n   = io_reset_r;
    core_reset_n = core_reset_r;

    unique case (state_r)
      e_lrs_idle, e_lrs_done: begin
        if (ctl_if.start_i) begin
          state_n      = e_lrs_assert;
          mask_n       = ctl_if.link_en_i;
          w_n          = ctl_if.wait_cycles_i;
          cnt_n        = ctl_if.wait_cycles_i;
          io_reset_n   = '1;
          core_reset_n = '1;
        end
      end
      e_lrs_assert: begin
        if (cnt_r != '0) begin
          cnt_n = cnt_r - 1'b1;
        end else if (!next_found) begin
          state_n = e_lrs_done;
        end else begin
          state_n              = e_lrs_io_rel;
          cur_n                = next_idx;
          cnt_n                = w_r;
          io_reset_n[next_idx] = 1'b0;
        end
      end
      e_lrs_io_rel: begin
        if (cnt_r != '0) begin
          cnt_n = cnt_r - 1'b1;
        end else begin
          state_n             = e_lrs_core_rel;
          cnt_n               = w_r;
          core_reset_n[cur_r] = 1'b0;
        end
      end
      e_lrs_core_rel: begin
        if (cnt_r != '0) begin
          cnt_n = cnt_r - 1'b1;
        end else if (next_found) begin
          state_n              = e_lrs_io_rel;
          cur_n                = next_idx;
          cnt_n                = w_r;
          io_reset_n[next_idx] = 1'b0;
        end else begin
          state_n = e_lrs_done;
        end
      end
      default: state_n = e_lrs_idle;
    endcase

    busy_n = (state_n == e_lrs_assert) || (state_n == e_lrs_io_rel) ||
             (state_n == e_lrs_core_rel);
    done_n = (state_n == e_lrs_done);
  end

  assign ctl_if.io_reset_o   = io_reset_r;
  assign ctl_if.core_reset_o = core_reset_r;
  assign ctl_if.cur_link_o   = cur_r;
  assign ctl_if.busy_o       = busy_r;
  assign ctl_if.done_o       = done_r;

endmodule
